// File: rtl/multi_ported_sram_lvt_init_pkg.sv
// Shared helpers and constants for the LVT-based multi-ported SRAM.
// Address/LVT width helpers, sequencer states and read-during-write modes.
package multi_ported_sram_pkg;

    function automatic int aw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lw_f(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_e;

    localparam int RDW_OLD    = 0;
    localparam int RDW_BYPASS = 1;

endpackage

// File: rtl/multi_ported_sram_lvt_init_if.sv
// Bus bundle for the multi-ported SRAM: read ports, write ports, init control.
// The master drives requests; the slave (memory) returns data and status.
interface multi_ported_sram_lvt_init_if #(
    parameter int NUM_W = 2,
    parameter int NUM_R = 2,
    parameter int W     = 32,
    parameter int AW    = 4
);
    logic [NUM_R-1:0]    ren;
    logic [NUM_R*AW-1:0] raddr;
    logic [NUM_R-1:0]    rvalid;
    logic [NUM_R*W-1:0]  rdata;
    logic [NUM_W-1:0]    wen;
    logic [NUM_W*AW-1:0] waddr;
    logic [NUM_W*W-1:0]  wdata;
    logic [NUM_W-1:0]    wconflict;
    logic                init;
    logic                busy_w;

    modport master (
        output ren, raddr, wen, waddr, wdata, init,
        input  rvalid, rdata, wconflict, busy_w
    );

    modport slave (
        input  ren, raddr, wen, waddr, wdata, init,
        output rvalid, rdata, wconflict, busy_w
    );
endinterface

// File: rtl/multi_ported_sram_lvt_init_fsm.sv
// Initialisation sequencer: sweeps every entry once, then hands bank 0
// and the LVT write path back to the user ports.
module multi_ported_sram_lvt_init_fsm
    import multi_ported_sram_pkg::*;
#(
    parameter int             N           = 16,
    parameter int             W           = 32,
    parameter int             AW          = 4,
    parameter int             INIT_ON_RST = 1,
    parameter logic [W-1:0]   INIT_VALUE  = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_init,
    input  logic          i_we0,
    input  logic [AW-1:0] i_addr0,
    input  logic [W-1:0]  i_data0,
    output logic          o_busy,
    output logic          o_we0,
    output logic [AW-1:0] o_addr0,
    output logic [W-1:0]  o_data0,
    output logic          o_lvt_we,
    output logic [AW-1:0] o_lvt_addr
);
    localparam logic [0:0]    S_IDLE = IDLE;
    localparam logic [0:0]    S_INIT = INIT;
    localparam logic [0:0]    S_RST  = (INIT_ON_RST != 0) ? S_INIT : S_IDLE;
    localparam logic [AW-1:0] LAST   = AW'(N - 1);

    logic [0:0]    r_state;
    logic [AW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RST;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_init) r_state <= S_INIT;
                end
                S_INIT: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == S_INIT);

    // The sweep owns bank 0 and the LVT while busy.
    assign o_we0      = o_busy ? 1'b1       : i_we0;
    assign o_addr0    = o_busy ? r_cnt      : i_addr0;
    assign o_data0    = o_busy ? INIT_VALUE : i_data0;
    assign o_lvt_we   = o_busy;
    assign o_lvt_addr = r_cnt;

endmodule

// File: rtl/multi_ported_sram_lvt_init.sv
// NUM_R-read / NUM_W-write memory: one bank per write port plus a
// Live-Value Table naming the port that last wrote each address.
module multi_ported_sram_lvt_init
    import multi_ported_sram_pkg::*;
#(
    parameter int           NUM_W       = 2,
    parameter int           NUM_R       = 2,
    parameter int           W           = 32,
    parameter int           N           = 16,
    parameter int           RDW_NEW     = 0,
    parameter int           INIT_ON_RST = 1,
    parameter logic [W-1:0] INIT_VALUE  = '0
) (
    input logic                      clk,
    input logic                      rst,
    multi_ported_sram_lvt_init_if.slave bus
);
    localparam int AW = aw_f(N);
    localparam int LW = lw_f(NUM_W);

    function automatic logic in_rng(input logic [AW-1:0] a);
        if ((1 << AW) == N) return 1'b1;
        return 32'(a) < 32'(N);
    endfunction

    logic [W-1:0]       r_bank [NUM_W][N];
    logic [NUM_R-1:0]   r_rvalid;
    logic [NUM_R*W-1:0] r_rdata;
    logic [NUM_W-1:0]   r_wconf;

    logic [AW-1:0]    w_wa   [NUM_W];
    logic [W-1:0]     w_wd   [NUM_W];
    logic [NUM_W-1:0] w_wok;
    logic [NUM_W-1:0] w_wdrop;
    logic [NUM_W-1:0] w_wwin;
    logic [AW-1:0]    w_ra   [NUM_R];
    logic [NUM_R-1:0] w_rok;
    logic [W-1:0]     w_rword[NUM_R];
    logic [NUM_R-1:0] w_byp;
    logic [W-1:0]     w_bypd [NUM_R];

    logic          w_busy;
    logic          w_we0;
    logic [AW-1:0] w_a0;
    logic [W-1:0]  w_d0;
    logic          w_lvt_we;
    logic [AW-1:0] w_lvt_addr;

    multi_ported_sram_lvt_init_fsm #(
        .N           (N),
        .W           (W),
        .AW          (AW),
        .INIT_ON_RST (INIT_ON_RST),
        .INIT_VALUE  (INIT_VALUE)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_init     (bus.init),
        .i_we0      (w_wwin[0]),
        .i_addr0    (w_wa[0]),
        .i_data0    (w_wd[0]),
        .o_busy     (w_busy),
        .o_we0      (w_we0),
        .o_addr0    (w_a0),
        .o_data0    (w_d0),
        .o_lvt_we   (w_lvt_we),
        .o_lvt_addr (w_lvt_addr)
    );

    // Highest-indexed enabled port wins a shared address.
    always_comb begin
        w_wdrop = '0;
        for (int j = 0; j < NUM_W; j++) begin
            w_wa[j]  = bus.waddr[j*AW +: AW];
            w_wd[j]  = bus.wdata[j*W +: W];
            w_wok[j] = bus.wen[j] && in_rng(w_wa[j]);
        end
        for (int j = 0; j < NUM_W; j++) begin
            for (int k = j + 1; k < NUM_W; k++) begin
                if (w_wok[j] && w_wok[k] && w_wa[k] == w_wa[j])
                    w_wdrop[j] = 1'b1;
            end
        end
        w_wwin = w_wok & ~w_wdrop & {NUM_W{~w_busy}};
    end

    always_comb begin
        for (int i = 0; i < NUM_R; i++) begin
            w_ra[i]   = bus.raddr[i*AW +: AW];
            w_rok[i]  = in_rng(w_ra[i]);
            w_byp[i]  = 1'b0;
            w_bypd[i] = '0;
            for (int j = 0; j < NUM_W; j++) begin
                if (w_wwin[j] && w_rok[i] && w_wa[j] == w_ra[i]) begin
                    w_byp[i]  = 1'b1;
                    w_bypd[i] = w_wd[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we0) r_bank[0][w_a0] <= w_d0;
        for (int j = 1; j < NUM_W; j++) begin
            if (w_wwin[j]) r_bank[j][w_wa[j]] <= w_wd[j];
        end
    end

    if (NUM_W > 1) begin : g_lvt
        logic [LW-1:0] r_lvt [N];

        always_ff @(posedge clk) begin
            if (w_lvt_we) r_lvt[w_lvt_addr] <= '0;
            for (int j = 0; j < NUM_W; j++) begin
                if (w_wwin[j]) r_lvt[w_wa[j]] <= LW'(j);
            end
        end

        // One-hot select of the live bank per read port.
        always_comb begin
            for (int i = 0; i < NUM_R; i++) begin
                w_rword[i] = '0;
                if (w_rok[i]) begin
                    for (int j = 0; j < NUM_W; j++) begin
                        if (r_lvt[w_ra[i]] == LW'(j))
                            w_rword[i] = w_rword[i] | r_bank[j][w_ra[i]];
                    end
                end
            end
        end
    end else begin : g_single
        always_comb begin
            for (int i = 0; i < NUM_R; i++) begin
                w_rword[i] = w_rok[i] ? r_bank[0][w_ra[i]] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_wconf  <= '0;
        end else begin
            r_rvalid <= bus.ren & {NUM_R{~w_busy}};
            r_wconf  <= w_busy ? '0 : w_wdrop;
            for (int i = 0; i < NUM_R; i++) begin
                if (bus.ren[i] && !w_busy) begin
                    r_rdata[i*W +: W] <=
                        (RDW_NEW == RDW_BYPASS && w_byp[i]) ?
                        w_bypd[i] : w_rword[i];
                end
            end
        end
    end

    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = r_rdata;
    assign bus.wconflict = r_wconf;
    assign bus.busy_w    = w_busy;

endmodule

// File: tb/tb_multi_ported_sram_lvt_init.sv
// Directed bench: two instances (old-data and bypass read-during-write)
// sharing clock and reset, checked with immediate assertions.
module tb_multi_ported_sram_lvt_init;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   n_fail;
    int   n;

    multi_ported_sram_lvt_init_if #(.NUM_W(2), .NUM_R(2), .W(32), .AW(4)) ifa ();
    multi_ported_sram_lvt_init_if #(.NUM_W(2), .NUM_R(2), .W(32), .AW(4)) ifb ();

    multi_ported_sram_lvt_init #(
        .NUM_W(2), .NUM_R(2), .W(32), .N(16),
        .RDW_NEW(0), .INIT_ON_RST(1), .INIT_VALUE(32'h0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    multi_ported_sram_lvt_init #(
        .NUM_W(2), .NUM_R(2), .W(32), .N(16),
        .RDW_NEW(1), .INIT_ON_RST(1), .INIT_VALUE(32'h0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ifa.ren = '0; ifa.raddr = '0; ifa.wen = '0;
        ifa.waddr = '0; ifa.wdata = '0; ifa.init = 1'b0;
        ifb.ren = '0; ifb.raddr = '0; ifb.wen = '0;
        ifb.waddr = '0; ifb.wdata = '0; ifb.init = 1'b0;
    endtask

    task automatic setw(input bit b, input int p, input logic [3:0] a,
                        input logic [31:0] d);
        if (!b) begin
            ifa.wen[p] = 1'b1;
            ifa.waddr[p*4 +: 4] = a;
            ifa.wdata[p*32 +: 32] = d;
        end else begin
            ifb.wen[p] = 1'b1;
            ifb.waddr[p*4 +: 4] = a;
            ifb.wdata[p*32 +: 32] = d;
        end
    endtask

    task automatic setr(input bit b, input int p, input logic [3:0] a);
        if (!b) begin
            ifa.ren[p] = 1'b1;
            ifa.raddr[p*4 +: 4] = a;
        end else begin
            ifb.ren[p] = 1'b1;
            ifb.raddr[p*4 +: 4] = a;
        end
    endtask

    task automatic cnt_busy(output int cnt);
        cnt = 0;
        while (ifa.busy_w && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        clr();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(ifa.busy_w), 64'h1);
        chk("rst_rvalid", 64'(ifa.rvalid), 64'h0);
        chk("rst_rdata", 64'(ifa.rdata), 64'h0);
        chk("rst_wconf", 64'(ifa.wconflict), 64'h0);

        // 1: power-on sweep lasts N cycles, every entry reads zero
        rst = 1'b0;
        cnt_busy(n);
        chk("por_busy_len", 64'(n), 64'd16);
        for (int a = 0; a < 16; a += 2) begin
            clr();
            setr(0, 0, 4'(a));
            setr(0, 1, 4'(a + 1));
            @(negedge clk);
            chk("por_rvalid", 64'(ifa.rvalid), 64'h3);
            chk("por_rdata", 64'(ifa.rdata), 64'h0);
        end

        // 2: successive writes from two ports; LVT picks the latest
        clr();
        setw(0, 0, 4'd3, 32'hAAAA_0001);
        @(negedge clk);
        clr();
        setw(0, 1, 4'd3, 32'hBBBB_0002);
        setr(0, 0, 4'd3);
        @(negedge clk);
        chk("t2_rdw_old", 64'(ifa.rdata[31:0]), 64'hAAAA_0001);
        clr();
        setr(0, 0, 4'd3);
        setr(0, 1, 4'd3);
        @(negedge clk);
        chk("t2_rvalid", 64'(ifa.rvalid), 64'h3);
        chk("t2_rd_p0", 64'(ifa.rdata[31:0]), 64'hBBBB_0002);
        chk("t2_rd_p1", 64'(ifa.rdata[63:32]), 64'hBBBB_0002);
        chk("t2_wconf", 64'(ifa.wconflict), 64'h0);
        clr();
        @(negedge clk);
        chk("t2_hold_rvalid", 64'(ifa.rvalid), 64'h0);
        chk("t2_hold_rdata", 64'(ifa.rdata[63:32]), 64'hBBBB_0002);

        // 3: same-cycle conflict, port 1 wins
        clr();
        setw(0, 0, 4'd5, 32'h11);
        setw(0, 1, 4'd5, 32'h22);
        @(negedge clk);
        chk("t3_wconf", 64'(ifa.wconflict), 64'h1);
        clr();
        setr(0, 0, 4'd5);
        @(negedge clk);
        chk("t3_wconf_clr", 64'(ifa.wconflict), 64'h0);
        chk("t3_rd", 64'(ifa.rdata[31:0]), 64'h22);

        // 4: read-during-write, old data versus bypass
        clr();
        setw(0, 0, 4'd7, 32'h5);
        setw(1, 0, 4'd7, 32'h5);
        @(negedge clk);
        clr();
        setw(0, 1, 4'd7, 32'h9);
        setw(1, 1, 4'd7, 32'h9);
        setr(0, 0, 4'd7);
        setr(1, 0, 4'd7);
        @(negedge clk);
        chk("t4_old", 64'(ifa.rdata[31:0]), 64'h5);
        chk("t4_new", 64'(ifb.rdata[31:0]), 64'h9);
        clr();
        setr(0, 1, 4'd7);
        setr(1, 1, 4'd7);
        @(negedge clk);
        chk("t4_after_a", 64'(ifa.rdata[63:32]), 64'h9);
        chk("t4_after_b", 64'(ifb.rdata[63:32]), 64'h9);
        clr();
        setw(1, 0, 4'd8, 32'h33);
        setw(1, 1, 4'd8, 32'h44);
        setr(1, 0, 4'd8);
        @(negedge clk);
        chk("t4_byp_win", 64'(ifb.rdata[31:0]), 64'h44);
        chk("t4_byp_conf", 64'(ifb.wconflict), 64'h1);

        // 5: init pulse, reset at sweep cycle 4, full re-run
        clr();
        ifa.init = 1'b1;
        @(negedge clk);
        clr();
        chk("t5_busy", 64'(ifa.busy_w), 64'h1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(ifa.busy_w), 64'h1);
        @(negedge clk);
        chk("t5_rst_rvalid", 64'(ifa.rvalid), 64'h0);
        chk("t5_rst_rdata", 64'(ifa.rdata), 64'h0);
        rst = 1'b0;
        cnt_busy(n);
        chk("t5_busy_len", 64'(n), 64'd16);
        clr();
        setr(0, 0, 4'd3);
        setr(0, 1, 4'd5);
        @(negedge clk);
        chk("t5_rd3", 64'(ifa.rdata[31:0]), 64'h0);
        chk("t5_rd5", 64'(ifa.rdata[63:32]), 64'h0);
        clr();
        setr(0, 0, 4'd7);
        setr(1, 0, 4'd8);
        @(negedge clk);
        chk("t5_rd7", 64'(ifa.rdata[31:0]), 64'h0);
        chk("t5_rd8", 64'(ifb.rdata[31:0]), 64'h0);

        // 6: user traffic and a second init pulse are ignored while busy
        clr();
        ifa.init = 1'b1;
        @(negedge clk);
        n = 0;
        while (ifa.busy_w && n < 100) begin
            clr();
            ifa.init = (n == 5);
            setw(0, 0, 4'd0, 32'hDEAD_0000);
            setw(0, 1, 4'd0, 32'hDEAD_0001);
            setr(0, 0, 4'd0);
            setr(0, 1, 4'd1);
            n++;
            @(negedge clk);
            chk("t6_rvalid", 64'(ifa.rvalid), 64'h0);
            chk("t6_wconf", 64'(ifa.wconflict), 64'h0);
        end
        chk("t6_busy_len", 64'(n), 64'd16);
        clr();
        setr(0, 0, 4'd0);
        setr(0, 1, 4'd1);
        @(negedge clk);
        chk("t6_rvalid_idle", 64'(ifa.rvalid), 64'h3);
        chk("t6_rd0", 64'(ifa.rdata[31:0]), 64'h0);
        chk("t6_rd1", 64'(ifa.rdata[63:32]), 64'h0);

        clr();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multi_ported_sram_lvt_init.md
Name: multi_ported_sram_lvt_init

Overview:
Parametrised NUM_R-read / NUM_W-write memory built from NUM_W banks of 1-read-per-port storage plus a Live-Value Table (LVT) recording which write port last wrote each address.
Adds the following:
- a hardware initialisation sequencer, with a busy indication
- deterministic write-write conflict resolution
- a selectable read-during-write mode
- a read-valid output
Sits under register-file and scoreboard structures needing more than one write per cycle.

Parameters:
NUM_W, 2, number of write ports (>=1)
NUM_R, 2, number of read ports (>=1)
W, 32, data word width
N, 16, entries (>=2; need not be a power of two)
RDW_NEW, 0, read-during-write same address: 0 = old data returned, 1 = new data bypassed
INIT_ON_RST, 1, 1 = start initialisation automatically on reset release
INIT_VALUE, 0, word written to every entry during initialisation (W bits)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ren  in  NUM_R  per-port read enable
raddr  in  NUM_R*$clog2(N)  packed read addresses, port i at [i*AW +: AW]
rvalid  out  NUM_R  registered read-data valid
rdata  out  NUM_R*W  registered read data, port i at [i*W +: W]
wen  in  NUM_W  per-port write enable
waddr  in  NUM_W*$clog2(N)  packed write addresses
wdata  in  NUM_W*W  packed write data
wconflict  out  NUM_W  registered; bit j = port j's write was dropped by a conflict
init  in  1  single-cycle request to (re)initialise all entries
busy_w  out  1  initialisation in progress

Behaviour:
- Reset (async): state = INIT if INIT_ON_RST else IDLE; init counter = 0; rvalid, wconflict = 0; rdata = 0. busy_w is driven from state (1 in INIT).
- FSM IDLE -> INIT:
  - on init=1 in IDLE;
  - init is ignored while in INIT.
- FSM INIT:
  - Each cycle, write INIT_VALUE to bank 0 at counter and LVT[counter] = 0.
  - Increment counter.
  - At counter == N-1, the write completes, then go to IDLE with the counter cleared.
  - Duration is exactly N cycles, with busy_w=1 throughout.
- While busy_w=1:
  - user wen/ren are ignored;
  - rvalid stays 0;
  - wconflict stays 0.
- Reset asserted mid-INIT aborts the sweep and returns to the reset state.
- Writes:
  - Port j writes bank j at waddr[j].
  - The LVT entry at waddr[j] is set to j.
  - Takes effect at the next rising edge.
- Conflict:
  - When several enabled ports target the same address, the highest index wins.
  - Lower ports are suppressed in both bank and LVT.
  - wconflict[j] pulses 1 the cycle after for each suppressed port.
- Address >= N on any port: the access is ignored (write dropped, read returns 0 with rvalid=1).
- Read latency 1:
  - ren[i] at cycle t gives rvalid[i]=1 and rdata at t+1.
  - LVT lookup and bank reads are both registered.
  - Output = bank[lvt_r][i] selected with a one-hot mux.
  - rdata holds its last value when rvalid=0.
- Read-during-write, same cycle, same address:
  - RDW_NEW=0 returns the pre-write value.
  - RDW_NEW=1 returns the winning port's wdata via a registered bypass.
- LVT entry width = max(1, $clog2(NUM_W)); NUM_W=1 degenerates to a single bank with no LVT mux.
- Address width AW = max(1, $clog2(N)).

Decomposition:
- Package multi_ported_sram_pkg holds:
  - AW/LVT-width helper functions;
  - the FSM state enum {IDLE, INIT};
  - the RDW mode constants.
- Natural sub-module: multi_ported_sram_lvt_init_fsm (sequencer, counter, busy_w, and the override mux for bank-0/LVT write port).
- Banks and LVT reuse the existing sram_1rNw and rf blocks.

Test Plan:
1. Reset with INIT_ON_RST=1, N=16 -> busy_w=1 for exactly 16 cycles; then reading every address returns 0x0000_0000.
2. Write port0 addr3=0xAAAA_0001, next cycle port1 addr3=0xBBBB_0002; then read ports 0 and 1 addr3 -> both return 0xBBBB_0002 one cycle after ren.
3. Same cycle: port0 and port1 both write addr5 (0x11, 0x22) -> mem[5]=0x22, wconflict=2'b01 the following cycle.
4. RDW_NEW=0: mem[7]=0x5; write 0x9 to addr7 and read addr7 in the same cycle -> rdata=0x5. Repeat with RDW_NEW=1 -> rdata=0x9.
5. Pulse init in IDLE after writes; assert rst at init cycle 4 -> busy_w follows the reset state; re-run completes, and all entries = INIT_VALUE.
6. ren and wen issued while busy_w=1 -> no rvalid, memory unchanged after initialisation completes.
